phys_reg_ready_table_8wide: RTL and testbench

- Per-physical-register ready/busy scoreboard, placed directly downstream of the 8-wide rename stage.
- Consumes renamed groups of up to 8 ops (`rd_phys`, `rs1_phys`, `rs2_phys`, valid), marks new destinations busy, clears busy on writeback broadcast.
- Produces a registered dispatch-stage group annotated with per-source ready bits for the reservation stations.
- Held (stalled) groups keep waking up from writebacks, so dispatch never sees stale readiness.

---
 rtl/rename_pkg.sv | 25 ++
 rtl/ready_lookup_8wide.sv | 36 +++
 rtl/phys_reg_ready_table_8wide.sv | 108 ++++++++++
 tb/tb_phys_reg_ready_table_8wide.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename/dispatch sizing, tag type and writeback match helper
package rename_pkg;

  localparam int PHYS_REGS  = 128;
  localparam int ARCH_REGS  = 32;
  localparam int WIDTH      = 8;
  localparam int WB_PORTS   = 4;
  localparam int PHYS_TAG_W = $clog2(PHYS_REGS);
  localparam int COUNT_W    = 8;

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

  // Tag 0 is hard-wired ready, so a broadcast of tag 0 never counts as a hit.
  function automatic logic wb_match(input phys_tag_t                tag,
                                    input logic [WB_PORTS-1:0]      wb_valid,
                                    input phys_tag_t [WB_PORTS-1:0] wb_phys);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && (wb_phys[p] == tag)) hit = 1'b1;
    end
    return hit && (tag != '0);
  endfunction

endpackage

// File: rtl/ready_lookup_8wide.sv
// rtl/ready_lookup_8wide.sv - per-slot source readiness: busy vector, wb bypass, intra-group RAW
module ready_lookup_8wide
  import rename_pkg::*;
(
  input  logic [PHYS_REGS-1:0]      busy,
  input  logic [WIDTH-1:0]          in_valid,
  input  phys_tag_t [WIDTH-1:0]     rd_phys,
  input  phys_tag_t [WIDTH-1:0]     rs1_phys,
  input  phys_tag_t [WIDTH-1:0]     rs2_phys,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  phys_tag_t [WB_PORTS-1:0]  wb_phys,
  output logic [WIDTH-1:0]          rs1_ready,
  output logic [WIDTH-1:0]          rs2_ready
);

  // An older slot in the same group producing the source overrides any bypass.
  function automatic logic src_ready(input int k, input phys_tag_t src);
    logic r;
    r = !busy[src] || wb_match(src, wb_valid, wb_phys);
    for (int j = 0; j < WIDTH; j++) begin
      if ((j < k) && in_valid[j] && (rd_phys[j] != '0) && (rd_phys[j] == src)) r = 1'b0;
    end
    if (src == '0) r = 1'b1;
    return r;
  endfunction

  always_comb begin
    rs1_ready = '0;
    rs2_ready = '0;
    for (int k = 0; k < WIDTH; k++) begin
      rs1_ready[k] = src_ready(k, rs1_phys[k]);
      rs2_ready[k] = src_ready(k, rs2_phys[k]);
    end
  end

endmodule

// File: rtl/phys_reg_ready_table_8wide.sv
// rtl/phys_reg_ready_table_8wide.sv - physical register busy scoreboard and dispatch ready annotation
module phys_reg_ready_table_8wide
  import rename_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_valid_i,
  input  phys_tag_t [WIDTH-1:0]     in_rd_phys_i,
  input  phys_tag_t [WIDTH-1:0]     in_rs1_phys_i,
  input  phys_tag_t [WIDTH-1:0]     in_rs2_phys_i,
  input  logic [WB_PORTS-1:0]       wb_valid_i,
  input  phys_tag_t [WB_PORTS-1:0]  wb_phys_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic [WIDTH-1:0]          out_valid_o,
  output phys_tag_t [WIDTH-1:0]     out_rd_phys_o,
  output phys_tag_t [WIDTH-1:0]     out_rs1_phys_o,
  output phys_tag_t [WIDTH-1:0]     out_rs2_phys_o,
  output logic [WIDTH-1:0]          out_rs1_ready_o,
  output logic [WIDTH-1:0]          out_rs2_ready_o,
  output logic [COUNT_W-1:0]        busy_count_o
);

  logic [PHYS_REGS-1:0] busy_q;
  logic [PHYS_REGS-1:0] busy_d;
  logic [COUNT_W-1:0]   count_d;
  logic [WIDTH-1:0]     lk_rs1_ready;
  logic [WIDTH-1:0]     lk_rs2_ready;
  logic [WIDTH-1:0]     hold_rs1_ready;
  logic [WIDTH-1:0]     hold_rs2_ready;

  ready_lookup_8wide u_lookup (
    .busy      (busy_q),
    .in_valid  (in_valid_i),
    .rd_phys   (in_rd_phys_i),
    .rs1_phys  (in_rs1_phys_i),
    .rs2_phys  (in_rs2_phys_i),
    .wb_valid  (wb_valid_i),
    .wb_phys   (wb_phys_i),
    .rs1_ready (lk_rs1_ready),
    .rs2_ready (lk_rs2_ready)
  );

  // Clears are applied before sets so a same-cycle realloc leaves the tag busy.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_i[p]) busy_d[wb_phys_i[p]] = 1'b0;
      end
      if (!stall_i) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (in_valid_i[k]) busy_d[in_rd_phys_i[k]] = 1'b1;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 1; i < PHYS_REGS; i++) begin
      count_d = count_d + COUNT_W'(busy_d[i]);
    end
  end

  // Held groups keep waking up so dispatch never sees stale readiness.
  always_comb begin
    hold_rs1_ready = '0;
    hold_rs2_ready = '0;
    for (int k = 0; k < WIDTH; k++) begin
      hold_rs1_ready[k] = out_rs1_ready_o[k] | wb_match(out_rs1_phys_o[k], wb_valid_i, wb_phys_i);
      hold_rs2_ready[k] = out_rs2_ready_o[k] | wb_match(out_rs2_phys_o[k], wb_valid_i, wb_phys_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q          <= '0;
      busy_count_o    <= '0;
      out_valid_o     <= '0;
      out_rd_phys_o   <= '0;
      out_rs1_phys_o  <= '0;
      out_rs2_phys_o  <= '0;
      out_rs1_ready_o <= '0;
      out_rs2_ready_o <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_o <= count_d;
      if (flush_i) begin
        out_valid_o <= '0;
      end else if (stall_i) begin
        out_rs1_ready_o <= hold_rs1_ready;
        out_rs2_ready_o <= hold_rs2_ready;
      end else begin
        out_valid_o     <= in_valid_i;
        out_rd_phys_o   <= in_rd_phys_i;
        out_rs1_phys_o  <= in_rs1_phys_i;
        out_rs2_phys_o  <= in_rs2_phys_i;
        out_rs1_ready_o <= lk_rs1_ready;
        out_rs2_ready_o <= lk_rs2_ready;
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_ready_table_8wide.sv
// tb/tb_phys_reg_ready_table_8wide.sv - self-checking bench for the phys reg ready table
module tb_phys_reg_ready_table_8wide;
  import rename_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [WIDTH-1:0]         in_valid;
  phys_tag_t [WIDTH-1:0]    in_rd, in_rs1, in_rs2;
  logic [WB_PORTS-1:0]      wb_valid;
  phys_tag_t [WB_PORTS-1:0] wb_phys;
  logic                     stall, flush;
  logic [WIDTH-1:0]         out_valid, out_r1, out_r2;
  phys_tag_t [WIDTH-1:0]    out_rd, out_s1, out_s2;
  logic [COUNT_W-1:0]       busy_count;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  bit                    mbusy [PHYS_REGS];
  logic [WIDTH-1:0]      m_valid = '0, m_r1 = '0, m_r2 = '0;
  phys_tag_t [WIDTH-1:0] m_rd = '0, m_s1 = '0, m_s2 = '0;
  int                    m_cnt = 0;

  phys_reg_ready_table_8wide dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_i      (in_valid),
    .in_rd_phys_i    (in_rd),
    .in_rs1_phys_i   (in_rs1),
    .in_rs2_phys_i   (in_rs2),
    .wb_valid_i      (wb_valid),
    .wb_phys_i       (wb_phys),
    .stall_i         (stall),
    .flush_i         (flush),
    .out_valid_o     (out_valid),
    .out_rd_phys_o   (out_rd),
    .out_rs1_phys_o  (out_s1),
    .out_rs2_phys_o  (out_s2),
    .out_rs1_ready_o (out_r1),
    .out_rs2_ready_o (out_r2),
    .busy_count_o    (busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit m_wb_has(input phys_tag_t t);
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p] && wb_phys[p] == t && t != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Scan older slots youngest-first; any earlier producer of src means not ready.
  function automatic bit m_ready(input int k, input phys_tag_t src);
    if (src == 0) return 1'b1;
    for (int j = k - 1; j >= 0; j--)
      if (in_valid[j] && in_rd[j] == src) return 1'b0;
    return !mbusy[src] || m_wb_has(src);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_valid = '0; m_r1 = '0; m_r2 = '0; m_rd = '0; m_s1 = '0; m_s2 = '0;
    end else if (flush) begin
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      m_valid = '0;
    end else begin
      if (stall) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (m_wb_has(m_s1[k])) m_r1[k] = 1'b1;
          if (m_wb_has(m_s2[k])) m_r2[k] = 1'b1;
        end
      end else begin
        for (int k = 0; k < WIDTH; k++) begin
          m_r1[k] = m_ready(k, in_rs1[k]);
          m_r2[k] = m_ready(k, in_rs2[k]);
        end
        m_valid = in_valid; m_rd = in_rd; m_s1 = in_rs1; m_s2 = in_rs2;
      end
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p]) mbusy[wb_phys[p]] = 1'b0;
      if (!stall)
        for (int k = 0; k < WIDTH; k++)
          if (in_valid[k] && in_rd[k] != 0) mbusy[in_rd[k]] = 1'b1;
    end
    m_cnt = 0;
    for (int i = 1; i < PHYS_REGS; i++) m_cnt += int'(mbusy[i]);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, m_valid);
      chk("out_rd", out_rd, m_rd);
      chk("out_rs1", out_s1, m_s1);
      chk("out_rs2", out_s2, m_s2);
      chk("rs1_ready", out_r1, m_r1);
      chk("rs2_ready", out_r2, m_r2);
      chk("busy_count", busy_count, m_cnt);
    end
  end

  task automatic clear_inputs();
    in_valid = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    wb_valid = '0; wb_phys = '0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    tick();
    chk("lit_reset_count", busy_count, 0);
    chk("lit_reset_valid", out_valid, 0);
    rst_n = 1'b1;

    // slot0 rd=40 rs1=5, slot1 rs1=40 depends on slot0
    in_valid = 8'b11; in_rd[0] = 7'd40; in_rs1[0] = 7'd5; in_rs1[1] = 7'd40;
    tick();
    chk("lit_g1_rs1_ready", out_r1, 8'hFD);
    chk("lit_g1_count", busy_count, 1);
    clear_inputs();

    // writeback bypass of 40
    in_valid = 8'b1; in_rs1[0] = 7'd40; wb_valid = 4'b0100; wb_phys[2] = 7'd40;
    tick();
    chk("lit_bypass_ready", out_r1[0], 1);
    chk("lit_bypass_count", busy_count, 0);
    clear_inputs();

    // held slot1 rs2=40 wakes up during stall
    in_valid = 8'b11; in_rd[0] = 7'd40; in_rs2[1] = 7'd40;
    tick();
    chk("lit_hold_pre", out_r2[1], 0);
    clear_inputs();
    stall = 1'b1; in_valid = 8'b1; in_rd[0] = 7'd60; wb_valid = 4'b1; wb_phys[0] = 7'd40;
    tick();
    chk("lit_hold_wake", out_r2[1], 1);
    chk("lit_hold_tag", out_s2[1], 40);
    chk("lit_hold_rd", out_rd[0], 40);
    chk("lit_hold_count", busy_count, 0);
    wb_valid = '0;
    tick();
    chk("lit_hold_noalloc", busy_count, 0);
    clear_inputs();

    // alloc and wb of 50 in the same cycle: set wins
    in_valid = 8'b1; in_rd[0] = 7'd50; wb_valid = 4'b1000; wb_phys[3] = 7'd50;
    tick();
    chk("lit_setwins_count", busy_count, 1);
    clear_inputs();
    in_valid = 8'b1; in_rs1[0] = 7'd50;
    tick();
    chk("lit_setwins_ready", out_r1[0], 0);
    clear_inputs();

    // all-zero tags across 8 slots
    in_valid = 8'hFF;
    tick();
    chk("lit_zero_rs1", out_r1, 8'hFF);
    chk("lit_zero_rs2", out_r2, 8'hFF);
    chk("lit_zero_count", busy_count, 1);
    clear_inputs();

    // 8 allocs, then flush with stall
    in_valid = 8'hFF;
    for (int k = 0; k < WIDTH; k++) in_rd[k] = phys_tag_t'(70 + k);
    tick();
    chk("lit_alloc8_count", busy_count, 9);
    flush = 1'b1; stall = 1'b1;
    tick();
    chk("lit_flush_valid", out_valid, 0);
    chk("lit_flush_count", busy_count, 0);
    clear_inputs();
    in_valid = 8'hFF;
    for (int k = 0; k < WIDTH; k++) begin
      in_rs1[k] = phys_tag_t'(70 + k);
      in_rs2[k] = phys_tag_t'(77 - k);
    end
    tick();
    chk("lit_postflush_rs1", out_r1, 8'hFF);
    chk("lit_postflush_rs2", out_r2, 8'hFF);
    clear_inputs();

    // mixed traffic over a small tag range to force collisions
    for (int c = 0; c < 80; c++) begin
      in_valid = 8'($urandom);
      for (int k = 0; k < WIDTH; k++) begin
        in_rd[k]  = phys_tag_t'($urandom_range(0, 15));
        in_rs1[k] = phys_tag_t'($urandom_range(0, 15));
        in_rs2[k] = phys_tag_t'($urandom_range(0, 15));
      end
      wb_valid = 4'($urandom);
      for (int p = 0; p < WB_PORTS; p++) wb_phys[p] = phys_tag_t'($urandom_range(0, 15));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    clear_inputs();
    repeat (3) tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
